// File: rtl/ram8_pkg.sv
// ---------------------------------------------------------------------------
// ram8_pkg
// Shared constants and types for the RAM8 register bank and for the larger
// RAM levels built from it.
//   WIDTH   : data width of one entry
//   DEPTH   : number of entries (fixed at 8 to match the 8-way mux)
//   ADDR_W  : address width, log2(DEPTH)
//   state_t : sweep controller states (IDLE, CLEAR)
// ---------------------------------------------------------------------------
package ram8_pkg;

   localparam int WIDTH  = 16;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

endpackage

// File: rtl/mux8way16.sv
// ---------------------------------------------------------------------------
// mux8way16
// 8-way WIDTH-bit selector used for both read paths of the register bank.
//   in  : the eight candidate words
//   sel : index of the word to forward
//   out : in[sel], purely combinational
// ---------------------------------------------------------------------------
module mux8way16
   import ram8_pkg::*;
(
   input  logic [WIDTH-1:0]  in [DEPTH],
   input  logic [ADDR_W-1:0] sel,
   output logic [WIDTH-1:0]  out
);

   // sel spans exactly 0..7, so every index lands on a real entry.
   assign out = in[sel];

endmodule

// File: rtl/register16.sv
// ---------------------------------------------------------------------------
// register16
// One WIDTH-bit storage word with load enable and a synchronous clear.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset, forces the word to zero
//   clear : synchronous clear, wins over load
//   load  : capture "in" on the next rising edge
//   in    : write data
//   out   : stored value
// ---------------------------------------------------------------------------
module register16
   import ram8_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
);

   // Clear has priority so the sweep always wins over a stray load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out <= '0;
      end else if (clear) begin
         out <= '0;
      end else if (load) begin
         out <= in;
      end
   end

endmodule

// File: rtl/ram8_16.sv
// ---------------------------------------------------------------------------
// ram8_16
// 8 x 16-bit register bank (Hack RAM8) with a combinational read, a
// registered read port and a hardware clear sweep.
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   in       : write data
//   load     : write enable for entry "address" (ignored while sweeping)
//   address  : write address and combinational read select
//   out      : contents of entry "address", combinational
//   rd_req   : registered read request (ignored while sweeping)
//   rd_addr  : registered read address
//   rd_data  : registered read data, holds its last value between reads
//   rd_valid : one-cycle pulse per accepted read request
//   clr      : start the clear sweep (sampled in IDLE only)
//   busy     : high during the 8 sweep cycles
// ---------------------------------------------------------------------------
module ram8_16
   import ram8_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  in,
   input  logic              load,
   input  logic [ADDR_W-1:0] address,
   output logic [WIDTH-1:0]  out,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data,
   output logic              rd_valid,
   input  logic              clr,
   output logic              busy
);

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] cnt;
   logic [ADDR_W-1:0] cnt_next;
   logic [DEPTH-1:0]  load_sel;
   logic [DEPTH-1:0]  clear_sel;
   logic [WIDTH-1:0]  entry [DEPTH];
   logic [WIDTH-1:0]  rd_mux_out;

   // Sweep controller state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Next state: the sweep visits entries 0..7, one per cycle, then returns
   // to IDLE on the edge that clears entry 7.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            if (clr) begin
               state_next = CLEAR;
               cnt_next   = '0;
            end
         end
         CLEAR: begin
            busy     = 1'b1;
            cnt_next = cnt + 3'd1;
            if (cnt == 3'(DEPTH - 1)) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // One-hot load/clear decode. Writes are only accepted in IDLE, including
   // the edge that starts a sweep; the entry written there is zeroed later.
   always_comb begin
      load_sel  = '0;
      clear_sel = '0;
      if (state == IDLE && load) begin
         load_sel[address] = 1'b1;
      end
      if (state == CLEAR) begin
         clear_sel[cnt] = 1'b1;
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      register16 u_reg (
         .clk   (clk),
         .rst_n (rst_n),
         .clear (clear_sel[i]),
         .load  (load_sel[i]),
         .in    (in),
         .out   (entry[i])
      );
   end

   mux8way16 u_out_mux (
      .in  (entry),
      .sel (address),
      .out (out)
   );

   mux8way16 u_rd_mux (
      .in  (entry),
      .sel (rd_addr),
      .out (rd_mux_out)
   );

   // Registered read samples the pre-edge entry value, so a same-edge write
   // to the same address returns the old data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else if (state == IDLE && rd_req) begin
         rd_data  <= rd_mux_out;
         rd_valid <= 1'b1;
      end else begin
         rd_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ram8_16.sv
// ---------------------------------------------------------------------------
// tb_ram8_16
// Randomised and directed bench for ram8_16 with a behavioural memory model
// and a queue-based scoreboard for the registered read port.
// ---------------------------------------------------------------------------
module tb_ram8_16;
   import ram8_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [WIDTH-1:0]  in;
   logic              load;
   logic [ADDR_W-1:0] address;
   logic [WIDTH-1:0]  out;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic [WIDTH-1:0]  rd_data;
   logic              rd_valid;
   logic              clr;
   logic              busy;

   ram8_16 dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in       (in),
      .load     (load),
      .address  (address),
      .out      (out),
      .rd_req   (rd_req),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .clr      (clr),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Reference model: plain array of words plus the index the sweep will
   // zero next (-1 when no sweep is running).
   logic [WIDTH-1:0] model_mem [DEPTH];
   int               sweep_pos;
   logic             exp_valid;
   logic [WIDTH-1:0] exp_q [$];
   logic [WIDTH-1:0] exp_pop;

   int checks;
   int passes;

   task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                              input logic [WIDTH-1:0] expected);
      checks++;
      if (actual === expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
      end
   endtask

   task automatic resetModel();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      sweep_pos = -1;
      exp_valid = 1'b0;
      exp_q.delete();
   endtask

   // Applies the rules of one rising edge to the model, using the inputs
   // that were present at that edge.
   task automatic modelStep();
      exp_valid = 1'b0;
      if (sweep_pos < 0) begin
         if (rd_req) begin
            exp_q.push_back(model_mem[rd_addr]);
            exp_valid = 1'b1;
         end
         if (load) model_mem[address] = in;
         if (clr) sweep_pos = 0;
      end else begin
         model_mem[sweep_pos] = '0;
         sweep_pos++;
         if (sweep_pos == DEPTH) sweep_pos = -1;
      end
   endtask

   task automatic setInputs(input logic ld, input logic [ADDR_W-1:0] addr,
                            input logic [WIDTH-1:0] din, input logic rq,
                            input logic [ADDR_W-1:0] raddr, input logic cl);
      load    = ld;
      address = addr;
      in      = din;
      rd_req  = rq;
      rd_addr = raddr;
      clr     = cl;
   endtask

   task automatic applyStimulus(input logic ld, input logic [ADDR_W-1:0] addr,
                                input logic [WIDTH-1:0] din, input logic rq,
                                input logic [ADDR_W-1:0] raddr, input logic cl);
      @(negedge clk);
      #1;
      setInputs(ld, addr, din, rq, raddr, cl);
      @(posedge clk);
      if (rst_n) modelStep();
   endtask

   // Monitor: compares the live outputs with the model each falling edge
   // and retires one scoreboard entry for every rd_valid pulse.
   always @(negedge clk) begin
      checkOutput("out", out, model_mem[address]);
      checkOutput("busy", {15'd0, busy}, {15'd0, (sweep_pos >= 0)});
      checkOutput("rd_valid", {15'd0, rd_valid}, {15'd0, exp_valid});
      if (rd_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("[TB] FAIL rd_unexpected at %0t: got data %h, expected no read", $time, rd_data);
         end else begin
            exp_pop = exp_q.pop_front();
            checkOutput("rd_data", rd_data, exp_pop);
         end
      end
   end

   initial begin
      checks = 0;
      passes = 0;
      resetModel();
      rst_n = 1'b0;
      setInputs(1'b0, '0, '0, 1'b0, '0, 1'b0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;

      // Fill every entry; out must still show 0 during each write cycle.
      for (int a = 0; a < DEPTH; a++) begin
         applyStimulus(1'b1, ADDR_W'(a), 16'h1111 * WIDTH'(a + 1), 1'b0, '0, 1'b0);
      end
      applyStimulus(1'b0, 3'd7, '0, 1'b0, '0, 1'b0);

      // Read-before-write on the same edge.
      applyStimulus(1'b1, 3'd3, 16'h1234, 1'b0, '0, 1'b0);
      applyStimulus(1'b1, 3'd3, 16'hBEEF, 1'b1, 3'd3, 1'b0);
      applyStimulus(1'b0, 3'd3, '0, 1'b0, '0, 1'b0);

      // Back-to-back registered reads, then the request drops.
      for (int a = 0; a < 4; a++) begin
         applyStimulus(1'b0, ADDR_W'(a), '0, 1'b1, ADDR_W'(a), 1'b0);
      end
      applyStimulus(1'b0, 3'd0, '0, 1'b0, '0, 1'b0);

      // Full sweep watched through entry 7, with ignored traffic inside it.
      applyStimulus(1'b0, 3'd7, '0, 1'b0, '0, 1'b1);
      for (int c = 0; c < DEPTH; c++) begin
         applyStimulus(1'b1, 3'd7, 16'hFFFF, 1'b1, 3'd7, 1'b1);
      end
      for (int a = 0; a < DEPTH; a++) begin
         applyStimulus(1'b0, ADDR_W'(a), '0, 1'b1, ADDR_W'(a), 1'b0);
      end

      // Write on the same edge that starts a sweep.
      applyStimulus(1'b1, 3'd5, 16'hAAAA, 1'b0, '0, 1'b1);
      for (int c = 0; c < DEPTH + 1; c++) begin
         applyStimulus(1'b0, 3'd5, '0, 1'b0, '0, 1'b0);
      end

      // Random traffic with occasional sweeps.
      for (int n = 0; n < 300; n++) begin
         applyStimulus(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, DEPTH - 1)),
                       WIDTH'($urandom), 1'($urandom_range(0, 1)),
                       ADDR_W'($urandom_range(0, DEPTH - 1)), ($urandom_range(0, 15) == 0));
      end

      // Fill, start a sweep, then pull reset between edges mid-sweep.
      for (int a = 0; a < DEPTH; a++) begin
         applyStimulus(1'b1, ADDR_W'(a), WIDTH'(16'h0F0F + a), 1'b1, ADDR_W'(a), 1'b0);
      end
      applyStimulus(1'b0, 3'd7, '0, 1'b0, '0, 1'b1);
      applyStimulus(1'b0, 3'd7, '0, 1'b0, '0, 1'b0);
      applyStimulus(1'b0, 3'd7, '0, 1'b0, '0, 1'b0);
      setInputs(1'b0, 3'd7, '0, 1'b0, '0, 1'b0);
      #2 rst_n = 1'b0;
      resetModel();
      #1;
      checkOutput("rst_out", out, '0);
      checkOutput("rst_busy", {15'd0, busy}, '0);
      checkOutput("rst_rd_valid", {15'd0, rd_valid}, '0);
      checkOutput("rst_rd_data", rd_data, '0);
      for (int a = 0; a < DEPTH; a++) begin
         address = ADDR_W'(a);
         #1 checkOutput("rst_entry", out, '0);
      end
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      setInputs(1'b1, 3'd2, 16'hC0DE, 1'b1, 3'd2, 1'b0);
      @(posedge clk);
      modelStep();
      applyStimulus(1'b0, 3'd2, '0, 1'b1, 3'd2, 1'b0);
      applyStimulus(1'b0, 3'd2, '0, 1'b0, '0, 1'b0);
      @(negedge clk);
      #1;

      checks++;
      if (exp_q.size() == 0) begin
         passes++;
      end else begin
         $display("[TB] FAIL rd_pending: got %0d outstanding reads, expected 0", exp_q.size());
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/ram8_16.md
Name: ram8_16

Overview:
- 8-entry x 16-bit register bank that directly feeds the team's 8-way 16-bit mux as its read path (Hack RAM8 equivalent).
- Provides two read paths:
  - combinational "out" of the register at "address", with Hack semantics;
  - one registered read port with a valid strobe, for pipelined consumers.
- Adds a hardware clear sweep (state machine) that zeroes all entries without a reset.

Parameters:
- WIDTH, 16, data width of each entry.
- DEPTH, 8, entry count; fixed at 8 to match the 8-way mux; other values unsupported.
- ADDR_W, 3, address width, log2(DEPTH).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in  input  WIDTH  write data.
- load  input  1  write enable for entry "address".
- address  input  ADDR_W  write address and combinational read select.
- out  output  WIDTH  current contents of entry "address", combinational.
- rd_req  input  1  registered-read request.
- rd_addr  input  ADDR_W  registered-read address.
- rd_data  output  WIDTH  registered-read data.
- rd_valid  output  1  rd_data valid, one-cycle pulse per accepted request.
- clr  input  1  start clear sweep (level sampled at edge).
- busy  output  1  high while clear sweep in progress.

Behaviour:
- Reset, asynchronous and immediate on rst_n low, including mid-sweep:
  - all 8 entries = 0;
  - rd_data = 0, rd_valid = 0, busy = 0;
  - state = IDLE, sweep counter = 0;
  - out = 0 (follows from entries).
- States:
  - IDLE: busy = 0.
  - CLEAR: busy = 1, 3-bit counter cnt.
- Write, IDLE only:
  - load = 1 at an edge: entry[address] <= in.
  - out shows the old value during the write cycle and the new value from the next cycle.
  - Zero added latency on out; purely a mux of stored values.
- Registered read, IDLE only:
  - rd_req = 1 at an edge: rd_data <= entry[rd_addr], using the pre-edge value; rd_valid <= 1.
  - Otherwise rd_valid <= 0 and rd_data holds its last value.
  - Latency is 1 cycle; back-to-back requests give one result per cycle.
  - Same-edge write and read to the same address: read-before-write, rd_data returns the old value.
- Clear sweep:
  - clr = 1 at an edge in IDLE: state -> CLEAR, cnt <= 0.
  - If load is also high at that edge, the write is performed at that edge (and is later zeroed).
  - If rd_req is also high at that edge, the read is serviced at that edge.
  - Each edge in CLEAR: entry[cnt] <= 0, cnt <= cnt + 1.
  - At the edge where cnt == 7: state -> IDLE.
  - busy is therefore high for exactly 8 cycles, starting the cycle after clr is sampled.
- During CLEAR:
  - load, rd_req and clr are ignored; rd_valid = 0.
  - out stays live and shows partially cleared contents.
- cnt wraps 7 -> 0 naturally; no other wrap conditions exist.
- No X on outputs after reset; address and rd_addr cover the full range, so there is no out-of-range case.

Decomposition:
- Shared package (ram8_pkg):
  - constants WIDTH = 16, DEPTH = 8, ADDR_W = 3;
  - state typedef {IDLE, CLEAR};
  - reused by the future ram64 level.
- Sub-module register16:
  - WIDTH-bit register with async active-low reset, load enable and synchronous clear input;
  - instantiated 8 times.
- Load/clear decode is a 3-to-8 one-hot decode, inline.
- out and rd_data selection use the existing 8-way 16-bit mux instances.

Test Plan:
1. Reset, then load address = 0..7 with in = 16'h1111 * (addr + 1) -> out reads 16'h1111..16'h8888 for address 0..7 the cycle after each write; the same-cycle out still shows 0.
2. Entry 3 = 16'h1234. Same edge: load = 1, address = 3, in = 16'hBEEF, rd_req = 1, rd_addr = 3 -> next cycle rd_data = 16'h1234, rd_valid = 1; out(address = 3) = 16'hBEEF.
3. rd_req held 4 cycles with rd_addr = 0,1,2,3 -> rd_valid high 4 consecutive cycles, rd_data = entries 0..3 in order; rd_valid low the cycle after rd_req drops.
4. All entries nonzero, pulse clr -> busy high exactly 8 cycles; out(address = 7) is nonzero until the last sweep edge. A load and rd_req issued during the sweep are ignored, with rd_valid = 0. After busy falls, all 8 entries read 0.
5. Same edge in IDLE: clr = 1 and load = 1, address = 5, in = 16'hAAAA -> entry 5 = 16'hAAAA for ≥1 cycle, then 0 once the sweep reaches it.
6. Drop rst_n asynchronously mid-sweep, between clock edges -> all outputs and entries are 0 immediately and busy = 0. After release, a normal write and read work on the first edge.
